// File: rtl/vote_tally_engine_if.sv
// rtl/vote_tally_engine_if.sv - button/mode/LED bundle for vote_tally_engine
interface vote_tally_engine_if #(
   parameter int NUM_CAND = 4,
   parameter int CNT_W    = 8
);
   localparam int IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

   logic                mode;
   logic [NUM_CAND-1:0] button;
   logic [CNT_W-1:0]    led;
   logic                vote_pulse;
   logic                vote_dropped;
   logic                sat;
   logic [IDX_W-1:0]    leader_idx;
   logic                leader_tie;

   modport master (
      output mode, button,
      input  led, vote_pulse, vote_dropped, sat, leader_idx, leader_tie
   );

   modport slave (
      input  mode, button,
      output led, vote_pulse, vote_dropped, sat, leader_idx, leader_tie
   );
endinterface

// File: rtl/vote_tally_engine.sv
// rtl/vote_tally_engine.sv - N-candidate debounced vote tally with ack lockout and result display (optional VOTE_LEADER_EN)
module vote_tally_engine #(
   parameter int NUM_CAND     = 4,
   parameter int CNT_W        = 8,
   parameter int DEBOUNCE_CYC = 100_000_000,
   parameter int ACK_CYC      = 100_000_000
) (
   input  logic               clock,
   input  logic               reset,
   vote_tally_engine_if.slave bus
);
   localparam int IDX_W  = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
   localparam int HOLD_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int ACK_W  = (ACK_CYC > 1) ? $clog2(ACK_CYC) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(DEBOUNCE_CYC);
   localparam logic [ACK_W-1:0]  ACK_LOAD = ACK_W'(ACK_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic [1:0] {S_VOTE, S_ACK, S_RESULT} state_t;

   state_t              state;
   logic [HOLD_W-1:0]   hold_cnt [NUM_CAND];
   logic [NUM_CAND-1:0] fired;
   logic [NUM_CAND-1:0] qual;
   logic [CNT_W-1:0]    count [NUM_CAND];
   logic [ACK_W-1:0]    ack_cnt;
   logic [CNT_W-1:0]    led_q;
   logic                vote_pulse_q;
   logic                vote_dropped_q;
   logic                sat_q;
   logic                any_qual;
   logic                multi_qual;
   logic [IDX_W-1:0]    win_idx;

   // Per-button hold counters; fired blocks repeat quals until the button is released.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CAND; i++) hold_cnt[i] <= '0;
         fired <= '0;
         qual  <= '0;
      end else begin
         for (int i = 0; i < NUM_CAND; i++) begin
            qual[i] <= (hold_cnt[i] == HOLD_MAX) && !fired[i];
            if (hold_cnt[i] == HOLD_MAX) fired[i] <= 1'b1;
            if (!bus.button[i]) begin
               hold_cnt[i] <= '0;
               fired[i]    <= 1'b0;
            end else if (hold_cnt[i] != HOLD_MAX) begin
               hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
            end
         end
      end
   end

   // Lowest-index qual wins; scanning downward leaves the lowest one in win_idx.
   always_comb begin
      any_qual   = 1'b0;
      multi_qual = 1'b0;
      win_idx    = '0;
      for (int i = NUM_CAND - 1; i >= 0; i--) begin
         if (qual[i]) begin
            if (any_qual) multi_qual = 1'b1;
            any_qual = 1'b1;
            win_idx  = IDX_W'(i);
         end
      end
   end

   // Main FSM: counts, ack lockout timer, result display and all registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= S_VOTE;
         for (int i = 0; i < NUM_CAND; i++) count[i] <= '0;
         ack_cnt        <= '0;
         led_q          <= '0;
         vote_pulse_q   <= 1'b0;
         vote_dropped_q <= 1'b0;
         sat_q          <= 1'b0;
      end else begin
         vote_pulse_q   <= 1'b0;
         vote_dropped_q <= 1'b0;
         case (state)
            S_VOTE: begin
               if (bus.mode) begin
                  state <= S_RESULT;
                  led_q <= '0;
               end else if (any_qual) begin
                  if (count[win_idx] != CNT_MAX)
                     count[win_idx] <= count[win_idx] + CNT_W'(1);
                  if (count[win_idx] == CNT_MAX - CNT_W'(1))
                     sat_q <= 1'b1;
                  vote_pulse_q   <= 1'b1;
                  vote_dropped_q <= multi_qual;
                  led_q          <= CNT_MAX;
                  ack_cnt        <= ACK_LOAD;
                  state          <= S_ACK;
               end else begin
                  led_q <= '0;
               end
            end
            S_ACK: begin
               if (bus.mode) begin
                  state <= S_RESULT;
                  led_q <= '0;
               end else begin
                  vote_dropped_q <= any_qual;
                  if (ack_cnt == '0) begin
                     state <= S_VOTE;
                     led_q <= '0;
                  end else begin
                     ack_cnt <= ack_cnt - ACK_W'(1);
                     led_q   <= CNT_MAX;
                  end
               end
            end
            S_RESULT: begin
               if (!bus.mode) begin
                  state <= S_VOTE;
                  led_q <= '0;
               end else if (any_qual) begin
                  led_q <= count[win_idx];
               end
            end
            default: begin
               state <= S_VOTE;
               led_q <= '0;
            end
         endcase
      end
   end

   assign bus.led          = led_q;
   assign bus.vote_pulse   = vote_pulse_q;
   assign bus.vote_dropped = vote_dropped_q;
   assign bus.sat          = sat_q;

`ifdef VOTE_LEADER_EN
   logic [CNT_W-1:0] best_val;
   logic [IDX_W-1:0] best_idx;
   logic             best_tie;
   logic [IDX_W-1:0] leader_idx_q;
   logic             leader_tie_q;

   // Running max over all counts; ties keep the lower index and flag the tie.
   always_comb begin
      best_val = count[0];
      best_idx = '0;
      best_tie = 1'b0;
      for (int i = 1; i < NUM_CAND; i++) begin
         if (count[i] > best_val) begin
            best_val = count[i];
            best_idx = IDX_W'(i);
            best_tie = 1'b0;
         end else if (count[i] == best_val) begin
            best_tie = 1'b1;
         end
      end
   end

   // Register the leader one cycle behind the counts.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         leader_idx_q <= '0;
         leader_tie_q <= 1'b0;
      end else begin
         leader_idx_q <= best_idx;
         leader_tie_q <= best_tie;
      end
   end

   assign bus.leader_idx = leader_idx_q;
   assign bus.leader_tie = leader_tie_q;
`else
   assign bus.leader_idx = '0;
   assign bus.leader_tie = 1'b0;
`endif
endmodule

// File: tb/tb_vote_tally_engine.sv
// tb/tb_vote_tally_engine.sv - directed self-checking bench for vote_tally_engine
module tb_vote_tally_engine;
   localparam int NC  = 4;
   localparam int CW  = 4;
   localparam int DEB = 4;
   localparam int ACK = 8;

   logic clock = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   bit   seen;

   vote_tally_engine_if #(.NUM_CAND(NC), .CNT_W(CW)) vif ();

   vote_tally_engine #(
      .NUM_CAND(NC), .CNT_W(CW), .DEBOUNCE_CYC(DEB), .ACK_CYC(ACK)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (vif)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cast_vote(input int idx);
      bit got = 1'b0;
      vif.button      = '0;
      vif.button[idx] = 1'b1;
      for (int k = 0; k < 30 && !got; k++) begin
         tick();
         got = vif.vote_pulse;
      end
      chk("vote_seen", 32'(got), 32'd1);
      vif.button = '0;
      for (int k = 0; k < 30 && vif.led !== '0; k++) tick();
      chk("ack_end", 32'(vif.led), 32'd0);
      tick();
   endtask

   // Result mode: led shows the selected count on the sixth edge after the press.
   task automatic read_cnt(input int idx, input logic [31:0] exp, input string tag);
      vif.button      = '0;
      vif.button[idx] = 1'b1;
      repeat (6) tick();
      chk(tag, 32'(vif.led), exp);
      chk("res_no_pulse", 32'(vif.vote_pulse), 32'd0);
      vif.button = '0;
      tick();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      vif.mode   = 1'b0;
      vif.button = '0;
      tick();
      chk("rst_led", 32'(vif.led), 32'd0);
      chk("rst_pulse", 32'(vif.vote_pulse), 32'd0);
      chk("rst_drop", 32'(vif.vote_dropped), 32'd0);
      chk("rst_sat", 32'(vif.sat), 32'd0);
      chk("rst_lidx", 32'(vif.leader_idx), 32'd0);
      chk("rst_ltie", 32'(vif.leader_tie), 32'd0);
      reset = 1'b0;
      tick();

      // 1: hold button[2] 15 cycles -> single vote at edge 5, ack edges 5..12
      vif.button = 4'b0100;
      for (int k = 0; k < 15; k++) begin
         tick();
         chk("t1_pulse", 32'(vif.vote_pulse), (k == 5) ? 32'd1 : 32'd0);
         chk("t1_led", 32'(vif.led), (k >= 5 && k <= 12) ? 32'hF : 32'h0);
      end
      vif.button = '0;
      tick();

      // 2: short presses never qualify
      for (int r = 0; r < 3; r++) begin
         vif.button = 4'b0010;
         repeat (3) begin
            tick();
            chk("t2_pulse", 32'(vif.vote_pulse), 32'd0);
            chk("t2_led", 32'(vif.led), 32'd0);
         end
         vif.button = '0;
         tick();
      end

      // 3: simultaneous 0/3 -> 0 wins, 3 dropped; button[1] during ack dropped at edge 11
      vif.button = 4'b1001;
      for (int k = 0; k < 17; k++) begin
         tick();
         chk("t3_pulse", 32'(vif.vote_pulse), (k == 5) ? 32'd1 : 32'd0);
         chk("t3_drop", 32'(vif.vote_dropped), (k == 5 || k == 11) ? 32'd1 : 32'd0);
         chk("t3_led", 32'(vif.led), (k >= 5 && k <= 12) ? 32'hF : 32'h0);
         if (k == 5) vif.button = 4'b0010;
      end
      vif.button = '0;
      tick();
      vif.mode = 1'b1;
      tick();
      chk("t3_res_led0", 32'(vif.led), 32'd0);
      read_cnt(0, 32'd1, "t3_cnt0");
      read_cnt(1, 32'd0, "t3_cnt1");
      read_cnt(2, 32'd1, "t3_cnt2");
      read_cnt(3, 32'd0, "t3_cnt3");
      vif.mode = 1'b0;
      tick();
      chk("t3_back_led", 32'(vif.led), 32'd0);

      // 4: 17 votes on button[1]; sat from the 15th, later votes still pulse
      for (int v = 1; v <= 17; v++) begin
         cast_vote(1);
         chk("t4_sat", 32'(vif.sat), (v >= 15) ? 32'd1 : 32'd0);
      end

      // 5: result mode reads, counts {1,F,1,0}
      vif.mode = 1'b1;
      tick();
      chk("t5_res_led0", 32'(vif.led), 32'd0);
      read_cnt(1, 32'hF, "t5_cnt1");
      read_cnt(2, 32'h1, "t5_cnt2");
      read_cnt(3, 32'h0, "t5_cnt3");
      vif.button = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t5_multi_led", 32'(vif.led), (k >= 5) ? 32'hF : 32'h0);
         chk("t5_multi_drop", 32'(vif.vote_dropped), 32'd0);
      end
      vif.button = '0;
      vif.mode   = 1'b0;
      tick();
      chk("t5_vote_led0", 32'(vif.led), 32'd0);
      // mode=1 mid-ack aborts ack on the next edge
      vif.button = 4'b0001;
      for (int k = 0; k < 11; k++) begin
         tick();
         chk("t5_ack_led", 32'(vif.led), (k >= 5 && k <= 7) ? 32'hF : 32'h0);
         if (k == 5) vif.button = '0;
         if (k == 7) vif.mode = 1'b1;
      end
      read_cnt(0, 32'd2, "t5_cnt0");
      read_cnt(1, 32'hF, "t5_cnt1_again");
      chk("t5_sat_pre", 32'(vif.sat), 32'd1);
      #3 reset = 1'b1;
      #1;
      chk("t5_async_led", 32'(vif.led), 32'd0);
      chk("t5_async_sat", 32'(vif.sat), 32'd0);
      @(posedge clock);
      #1;
      reset    = 1'b0;
      vif.mode = 1'b0;
      tick();

      // 6: counts {3,1,0,2}, reset asserted mid-ack of the last vote
      cast_vote(0);
      cast_vote(0);
      cast_vote(0);
      cast_vote(1);
      cast_vote(3);
`ifdef VOTE_LEADER_EN
      chk("t6_lidx_a", 32'(vif.leader_idx), 32'd0);
      chk("t6_ltie_a", 32'(vif.leader_tie), 32'd0);
`endif
      vif.button = 4'b1000;
      seen       = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         tick();
         seen = vif.vote_pulse;
      end
      chk("t6_vote", 32'(seen), 32'd1);
      vif.button = '0;
      tick();
      tick();
      chk("t6_mid_ack_led", 32'(vif.led), 32'hF);
      #3 reset = 1'b1;
      #1;
      chk("t6_async_led", 32'(vif.led), 32'd0);
      chk("t6_async_sat", 32'(vif.sat), 32'd0);
      chk("t6_async_pulse", 32'(vif.vote_pulse), 32'd0);
      chk("t6_async_lidx", 32'(vif.leader_idx), 32'd0);
      chk("t6_async_ltie", 32'(vif.leader_tie), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      tick();
      cast_vote(1);
      vif.mode = 1'b1;
      tick();
      read_cnt(1, 32'd1, "t6_cnt1");
      read_cnt(0, 32'd0, "t6_cnt0");
      read_cnt(3, 32'd0, "t6_cnt3");
      vif.mode = 1'b0;
      tick();

`ifdef VOTE_LEADER_EN
      chk("t6_lidx_b", 32'(vif.leader_idx), 32'd1);
      chk("t6_ltie_b", 32'(vif.leader_tie), 32'd0);
      repeat (2) cast_vote(0);
      repeat (4) cast_vote(1);
      repeat (5) cast_vote(2);
      cast_vote(3);
      chk("t6_lidx_c", 32'(vif.leader_idx), 32'd1);
      chk("t6_ltie_c", 32'(vif.leader_tie), 32'd1);
`else
      chk("t6_lidx_off", 32'(vif.leader_idx), 32'd0);
      chk("t6_ltie_off", 32'(vif.leader_tie), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
